// File: rtl/wb_master_cmd.sv
// Wishbone B4 pipelined initiator: one command in, one single-beat bus
// transaction out, one response back; a watchdog turns silence into rsp_err.
module wb_master_cmd #(
    parameter int TIMEOUT = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_adr,
    input  logic [31:0] cmd_dat,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_dat,
    output logic        rsp_err,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_stall_i
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        RESP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          cyc_d, stb_d, we_d, rsp_valid_d, rsp_err_d;
    logic [31:0]   adr_d, dat_d, rsp_dat_d;
    logic          ack_ok;

    assign cmd_ready = (state_q == IDLE);

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            wb_cyc_o  <= 1'b0;
            wb_stb_o  <= 1'b0;
            wb_we_o   <= 1'b0;
            wb_adr_o  <= '0;
            wb_dat_o  <= '0;
            rsp_valid <= 1'b0;
            rsp_dat   <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wb_cyc_o  <= cyc_d;
            wb_stb_o  <= stb_d;
            wb_we_o   <= we_d;
            wb_adr_o  <= adr_d;
            wb_dat_o  <= dat_d;
            rsp_valid <= rsp_valid_d;
            rsp_dat   <= rsp_dat_d;
            rsp_err   <= rsp_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cyc_d       = wb_cyc_o;
        stb_d       = wb_stb_o;
        we_d        = wb_we_o;
        adr_d       = wb_adr_o;
        dat_d       = wb_dat_o;
        rsp_valid_d = rsp_valid;
        rsp_dat_d   = rsp_dat;
        rsp_err_d   = rsp_err;
        ack_ok      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    we_d    = cmd_we;
                    adr_d   = cmd_adr;
                    dat_d   = cmd_dat;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = REQ;
                end
            end
            REQ, WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (state_q == REQ && !wb_stall_i) begin
                    stb_d   = 1'b0;
                    state_d = WAIT;
                end
                // An ack while the request is still stalled is not ours.
                ack_ok = wb_ack_i && (state_q == WAIT || !wb_stall_i);
                if (ack_ok) begin
                    rsp_dat_d   = wb_we_o ? 32'd0 : wb_dat_i;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    state_d     = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rsp_dat_d   = 32'd0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_wb_master_cmd.sv
// Bench for wb_master_cmd: vector table, hand sequences and random
// transactions checked against a transaction-level model.
module tb_wb_master_cmd;

    localparam int TO = 8;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [31:0] cmd_adr = '0;
    logic [31:0] cmd_dat = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [31:0] wb_adr_o, wb_dat_o;
    logic [31:0] wb_dat_i = '0;
    logic        wb_ack_i = 1'b0;
    logic        wb_stall_i = 1'b0;

    int n_chk = 0;
    int n_fail = 0;

    wb_master_cmd #(.TIMEOUT(TO)) dut (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_i  (wb_rst_i),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_adr   (cmd_adr),
        .cmd_dat   (cmd_dat),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_dat   (rsp_dat),
        .rsp_err   (rsp_err),
        .wb_cyc_o  (wb_cyc_o),
        .wb_stb_o  (wb_stb_o),
        .wb_we_o   (wb_we_o),
        .wb_adr_o  (wb_adr_o),
        .wb_dat_o  (wb_dat_o),
        .wb_dat_i  (wb_dat_i),
        .wb_ack_i  (wb_ack_i),
        .wb_stall_i(wb_stall_i)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        int          nstall;
        int          ackdly;
        logic [31:0] rdat;
        int          hold;
        logic [31:0] x_dat;
        logic        x_err;
        int          x_cyc;
        int          x_stb;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    // Transaction-level reference: when does the response arrive and what is it.
    function automatic void model(input logic we, input int nstall,
                                  input int ackdly, input logic [31:0] rdat,
                                  output logic [31:0] e_dat, output logic e_err,
                                  output int e_cyc, output int e_stb);
        int done;
        done = (ackdly < 0) ? 1 << 20 : nstall + 1 + ackdly;
        if (done <= TO) begin
            e_err = 1'b0;
            e_cyc = done;
            e_stb = nstall + 1;
            e_dat = we ? 32'd0 : rdat;
        end else begin
            e_err = 1'b1;
            e_cyc = TO;
            e_stb = (nstall + 1 < TO) ? nstall + 1 : TO;
            e_dat = 32'd0;
        end
    endfunction

    // Edge 0 accepts the command; stall is high on edges 1..nstall;
    // ack is high on edge nstall+1+ackdly (never if ackdly < 0).
    task automatic run_txn(input logic we, input logic [31:0] adr,
                           input logic [31:0] dat, input int nstall,
                           input int ackdly, input logic [31:0] rdat,
                           input int hold, output logic [31:0] r_dat,
                           output logic r_err, output int cyc_n,
                           output int stb_n, output int rsp_edge,
                           output logic stable, output logic hold_ok,
                           output logic ready_ok);
        int e;
        cmd_valid  = 1'b1;
        cmd_we     = we;
        cmd_adr    = adr;
        cmd_dat    = dat;
        wb_stall_i = 1'($urandom);
        wb_ack_i   = 1'b0;
        tick();
        cmd_valid = 1'b0;
        cmd_we    = ~we;
        cmd_adr   = $urandom;
        cmd_dat   = $urandom;
        e = 0;
        rsp_edge = -1;
        cyc_n = 0;
        stb_n = 0;
        stable = 1'b1;
        while (e < 64 && rsp_edge < 0) begin
            if (rsp_valid) begin
                rsp_edge = e;
            end else begin
                if (wb_cyc_o) cyc_n++;
                if (wb_stb_o) stb_n++;
                if (wb_cyc_o && (wb_adr_o !== adr || wb_we_o !== we ||
                    wb_dat_o !== dat || cmd_ready !== 1'b0))
                    stable = 1'b0;
                e++;
                wb_stall_i = (e <= nstall);
                wb_ack_i   = (ackdly >= 0) && (e == nstall + 1 + ackdly);
                wb_dat_i   = wb_ack_i ? rdat : $urandom;
                tick();
            end
        end
        r_dat = rsp_dat;
        r_err = rsp_err;
        hold_ok = (cmd_ready === 1'b0) && (wb_cyc_o === 1'b0);
        for (int i = 0; i < hold; i++) begin
            wb_ack_i   = 1'($urandom);
            wb_stall_i = 1'($urandom);
            wb_dat_i   = $urandom;
            cmd_valid  = 1'b1;
            cmd_adr    = 32'hBAD0_0000;
            tick();
            if (rsp_valid !== 1'b1 || rsp_dat !== r_dat || rsp_err !== r_err ||
                cmd_ready !== 1'b0 || wb_cyc_o !== 1'b0)
                hold_ok = 1'b0;
        end
        wb_ack_i  = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        ready_ok = (cmd_ready === 1'b1) && (rsp_valid === 1'b0) &&
                   (wb_cyc_o === 1'b0);
    endtask

    task automatic check_txn(input string tag, input vec_t v);
        logic [31:0] r_dat;
        logic        r_err, stable, hold_ok, ready_ok;
        int          cyc_n, stb_n, rsp_edge;
        run_txn(v.we, v.adr, v.dat, v.nstall, v.ackdly, v.rdat, v.hold,
                r_dat, r_err, cyc_n, stb_n, rsp_edge, stable, hold_ok, ready_ok);
        chk({tag, ".rsp_dat"}, r_dat, v.x_dat);
        chk({tag, ".rsp_err"}, 32'(r_err), 32'(v.x_err));
        chk({tag, ".cyc_len"}, cyc_n, v.x_cyc);
        chk({tag, ".stb_len"}, stb_n, v.x_stb);
        chk({tag, ".rsp_edge"}, rsp_edge, v.x_cyc);
        chk({tag, ".bus_stable"}, 32'(stable), 32'd1);
        chk({tag, ".rsp_hold"}, 32'(hold_ok), 32'd1);
        chk({tag, ".ready_after"}, 32'(ready_ok), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        vec_t vecs[8];
        vec_t rv;

        vecs[0] = '{1'b1, 32'h4, 32'hA, 0, 1, 32'h5555_5555, 0,
                    32'h0, 1'b0, 2, 1};
        vecs[1] = '{1'b0, 32'h10, 32'h0, 3, 1, 32'hDEAD_BEEF, 0,
                    32'hDEAD_BEEF, 1'b0, 5, 4};
        vecs[2] = '{1'b0, 32'h20, 32'h0, 0, -1, 32'h1111_1111, 0,
                    32'h0, 1'b1, 8, 1};
        vecs[3] = '{1'b0, 32'h24, 32'h0, 0, 7, 32'h1234_5678, 0,
                    32'h1234_5678, 1'b0, 8, 1};
        vecs[4] = '{1'b0, 32'h28, 32'h0, 2, 0, 32'h0000_CAFE, 1,
                    32'h0000_CAFE, 1'b0, 3, 3};
        vecs[5] = '{1'b0, 32'h2C, 32'h0, 10, 1, 32'h2222_2222, 0,
                    32'h0, 1'b1, 8, 8};
        vecs[6] = '{1'b0, 32'h30, 32'h0, 0, 8, 32'h3333_3333, 0,
                    32'h0, 1'b1, 8, 1};
        vecs[7] = '{1'b1, 32'h34, 32'hFEED_F00D, 1, 2, 32'h4444_4444, 5,
                    32'h0, 1'b0, 4, 2};

        #12;
        chk("rst.cyc", 32'(wb_cyc_o), 32'd0);
        chk("rst.stb", 32'(wb_stb_o), 32'd0);
        chk("rst.we", 32'(wb_we_o), 32'd0);
        chk("rst.adr", wb_adr_o, 32'd0);
        chk("rst.dat", wb_dat_o, 32'd0);
        chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst.rsp_dat", rsp_dat, 32'd0);
        chk("rst.rsp_err", 32'(rsp_err), 32'd0);
        chk("rst.cmd_ready", 32'(cmd_ready), 32'd1);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        tick();

        for (int i = 0; i < 8; i++)
            check_txn($sformatf("vec%0d", i), vecs[i]);

        // Async reset between edges while waiting for an ack.
        cmd_valid  = 1'b1;
        cmd_we     = 1'b0;
        cmd_adr    = 32'h40;
        wb_stall_i = 1'b0;
        wb_ack_i   = 1'b0;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        chk("arst.pre_cyc", 32'(wb_cyc_o), 32'd1);
        chk("arst.pre_stb", 32'(wb_stb_o), 32'd0);
        #3;
        wb_rst_i = 1'b1;
        #1;
        chk("arst.cyc", 32'(wb_cyc_o), 32'd0);
        chk("arst.stb", 32'(wb_stb_o), 32'd0);
        chk("arst.rsp_valid", 32'(rsp_valid), 32'd0);
        wb_ack_i = 1'b1;
        wb_dat_i = 32'h7777_7777;
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        tick();
        wb_ack_i = 1'b0;
        chk("arst.cmd_ready", 32'(cmd_ready), 32'd1);
        chk("arst.late_ack_cyc", 32'(wb_cyc_o), 32'd0);
        chk("arst.late_ack_rsp", 32'(rsp_valid), 32'd0);

        for (int i = 0; i < 40; i++) begin
            rv.we     = 1'($urandom);
            rv.adr    = $urandom;
            rv.dat    = $urandom;
            rv.nstall = int'($urandom_range(0, 4));
            rv.ackdly = int'($urandom_range(0, 10)) - 1;
            rv.rdat   = $urandom;
            rv.hold   = int'($urandom_range(0, 3));
            model(rv.we, rv.nstall, rv.ackdly, rv.rdat,
                  rv.x_dat, rv.x_err, rv.x_cyc, rv.x_stb);
            check_txn($sformatf("rnd%0d", i), rv);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
